// File: rtl/cam_cntrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cam_cntrl_pkg : state, descriptor types and length helper for msg_cam_cntrl
// Revision 1.0
// ---------------------------------------------------------------------------
package cam_cntrl_pkg;

  localparam int CAM_ADDR_W = 5;
  localparam int CAM_LEN_W  = CAM_ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IN_MSG = 2'd1,
    ST_DROP   = 2'd2
  } cam_cntrl_state_e;

  typedef struct packed {
    logic [CAM_ADDR_W-1:0] start;
    logic [CAM_ADDR_W-1:0] end_idx;
    logic [CAM_LEN_W-1:0]  len;
  } cam_desc_t;

  // Ring distance first..last inclusive; a full-ring message wraps to 0 and is reported as depth.
  function automatic logic [31:0] msg_len(input logic [31:0] first,
                                          input logic [31:0] last,
                                          input logic [31:0] depth);
    logic [31:0] l;
    l = (last - first + 32'd1) & (depth - 32'd1);
    return (l == 32'd0) ? depth : l;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msg_desc_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// msg_desc_fifo : synchronous show-ahead FIFO holding completed message descriptors
// Revision 1.0
// ---------------------------------------------------------------------------
module msg_desc_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] c_ptr_one = (PW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer bit separates full from empty when the index bits match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/msg_cam_cntrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// msg_cam_cntrl : framed beat stream -> CAM ring writer with descriptor queue.
// Optional MSG_CAM_CNTRL_STATS_EN adds saturating message/drop counters.
// Revision 1.0
// ---------------------------------------------------------------------------
module msg_cam_cntrl
  import cam_cntrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DESC_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  start_message_i,
  input  logic                  end_message_i,
  output logic                  cam_wr_o,
  output logic [ADDR_WIDTH-1:0] cam_wr_index_o,
  output logic [DATA_WIDTH-1:0] cam_wr_data_o,
  output logic                  desc_valid_o,
  output logic [ADDR_WIDTH-1:0] desc_start_o,
  output logic [ADDR_WIDTH-1:0] desc_end_o,
  output logic [ADDR_WIDTH:0]   desc_len_o,
  input  logic                  desc_ready_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  drop_o,
  output logic                  err_o
`ifdef MSG_CAM_CNTRL_STATS_EN
  ,
  output logic [15:0]           msg_cnt_o,
  output logic [15:0]           drop_cnt_o
`endif
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int DW    = 2*ADDR_WIDTH + CW;
  localparam logic [CW-1:0]         c_depth   = CW'(DEPTH);
  localparam logic [CW-1:0]         c_one     = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] c_ptr_one = ADDR_WIDTH'(1);

  cam_cntrl_state_e      r_state, w_state_n;
  logic [ADDR_WIDTH-1:0] r_wr_ptr, w_wr_ptr_n;
  logic [ADDR_WIDTH-1:0] r_msg_start, w_msg_start_n;
  logic [CW-1:0]         r_msg_beats, w_msg_beats_n;
  logic [CW-1:0]         r_count;
  logic                  r_cam_wr;
  logic [ADDR_WIDTH-1:0] r_cam_idx;
  logic [DATA_WIDTH-1:0] r_cam_data;
  logic                  r_drop;
  logic                  r_err;

  logic [ADDR_WIDTH-1:0] w_base_ptr;
  logic [CW-1:0]         w_rewind;
  logic                  w_write, w_push, w_drop, w_err;
  logic [ADDR_WIDTH-1:0] w_desc_start, w_desc_end;
  logic [CW-1:0]         w_desc_len;
  logic                  w_fifo_full, w_fifo_empty, w_pop;
  logic [DW-1:0]         w_fifo_dout;
  logic [ADDR_WIDTH-1:0] w_head_start, w_head_end;
  logic [CW-1:0]         w_head_len, w_pop_len;

  assign {w_head_start, w_head_end, w_head_len} = w_fifo_dout;
  assign w_pop     = desc_ready_i && !w_fifo_empty;
  assign w_pop_len = w_pop ? w_head_len : '0;

  always_comb begin
    w_state_n     = r_state;
    w_wr_ptr_n    = r_wr_ptr;
    w_msg_start_n = r_msg_start;
    w_msg_beats_n = r_msg_beats;
    w_base_ptr    = r_wr_ptr;
    w_rewind      = '0;
    w_write       = 1'b0;
    w_push        = 1'b0;
    w_drop        = 1'b0;
    w_err         = 1'b0;
    w_desc_start  = r_wr_ptr;
    w_desc_end    = r_wr_ptr;
    w_desc_len    = c_one;
    if (wr_en_i) begin
      if (start_message_i) begin
        // A start inside a message abandons it; the new one reuses its space.
        if (r_state == ST_IN_MSG) begin
          w_err      = 1'b1;
          w_base_ptr = r_msg_start;
          w_rewind   = r_msg_beats;
        end
        w_wr_ptr_n   = w_base_ptr;
        w_desc_start = w_base_ptr;
        w_desc_end   = w_base_ptr;
        w_state_n    = ST_IDLE;
        if (((r_count - w_rewind) == c_depth) || (end_message_i && w_fifo_full)) begin
          w_drop = 1'b1;
          if (!end_message_i) w_state_n = ST_DROP;
        end else begin
          w_write    = 1'b1;
          w_wr_ptr_n = w_base_ptr + c_ptr_one;
          if (end_message_i) begin
            w_push = 1'b1;
          end else begin
            w_state_n     = ST_IN_MSG;
            w_msg_start_n = w_base_ptr;
            w_msg_beats_n = c_one;
          end
        end
      end else begin
        case (r_state)
          ST_IDLE: w_err = 1'b1;
          ST_IN_MSG: begin
            if (r_count == c_depth) begin
              w_drop     = 1'b1;
              w_rewind   = r_msg_beats;
              w_wr_ptr_n = r_msg_start;
              w_state_n  = ST_DROP;
            end else if (end_message_i && w_fifo_full) begin
              w_drop     = 1'b1;
              w_rewind   = r_msg_beats;
              w_wr_ptr_n = r_msg_start;
              w_state_n  = ST_IDLE;
            end else begin
              w_write       = 1'b1;
              w_wr_ptr_n    = r_wr_ptr + c_ptr_one;
              w_msg_beats_n = r_msg_beats + c_one;
              if (end_message_i) begin
                w_push       = 1'b1;
                w_desc_start = r_msg_start;
                w_desc_end   = r_wr_ptr;
                w_desc_len   = CW'(msg_len(32'(r_msg_start), 32'(r_wr_ptr), 32'(DEPTH)));
                w_state_n    = ST_IDLE;
              end
            end
          end
          ST_DROP: if (end_message_i) w_state_n = ST_IDLE;
          default: w_state_n = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_msg_start <= '0;
      r_msg_beats <= '0;
      r_count     <= '0;
      r_cam_wr    <= 1'b0;
      r_cam_idx   <= '0;
      r_cam_data  <= '0;
      r_drop      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_wr_ptr    <= w_wr_ptr_n;
      r_msg_start <= w_msg_start_n;
      r_msg_beats <= w_msg_beats_n;
      r_count     <= r_count - w_rewind + CW'(w_write) - w_pop_len;
      r_cam_wr    <= w_write;
      r_drop      <= w_drop;
      r_err       <= w_err;
      if (w_write) begin
        r_cam_idx  <= w_base_ptr;
        r_cam_data <= data_i;
      end
    end
  end

  msg_desc_fifo #(
    .WIDTH (DW),
    .DEPTH (DESC_DEPTH)
  ) u_desc_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({w_desc_start, w_desc_end, w_desc_len}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign cam_wr_o       = r_cam_wr;
  assign cam_wr_index_o = r_cam_idx;
  assign cam_wr_data_o  = r_cam_data;
  assign desc_valid_o   = !w_fifo_empty;
  assign desc_start_o   = w_fifo_empty ? '0 : w_head_start;
  assign desc_end_o     = w_fifo_empty ? '0 : w_head_end;
  assign desc_len_o     = w_fifo_empty ? '0 : w_head_len;
  assign full_o         = (r_count == c_depth);
  assign empty_o        = (r_count == '0);
  assign count_o        = r_count;
  assign drop_o         = r_drop;
  assign err_o          = r_err;

`ifdef MSG_CAM_CNTRL_STATS_EN
  logic [15:0] r_msg_cnt;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_msg_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push && (r_msg_cnt != 16'hFFFF))  r_msg_cnt  <= r_msg_cnt + 16'd1;
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign msg_cnt_o  = r_msg_cnt;
  assign drop_cnt_o = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_msg_cam_cntrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_msg_cam_cntrl : randomized + directed scoreboard bench for msg_cam_cntrl
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_msg_cam_cntrl;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DD    = 2;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en_i;
  logic [DW-1:0] data_i;
  logic          start_message_i;
  logic          end_message_i;
  logic          cam_wr_o;
  logic [AW-1:0] cam_wr_index_o;
  logic [DW-1:0] cam_wr_data_o;
  logic          desc_valid_o;
  logic [AW-1:0] desc_start_o;
  logic [AW-1:0] desc_end_o;
  logic [AW:0]   desc_len_o;
  logic          desc_ready_i;
  logic          full_o;
  logic          empty_o;
  logic [AW:0]   count_o;
  logic          drop_o;
  logic          err_o;

  always #5 clk = ~clk;

  msg_cam_cntrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DESC_DEPTH(DD)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en_i), .data_i(data_i),
    .start_message_i(start_message_i), .end_message_i(end_message_i),
    .cam_wr_o(cam_wr_o), .cam_wr_index_o(cam_wr_index_o), .cam_wr_data_o(cam_wr_data_o),
    .desc_valid_o(desc_valid_o), .desc_start_o(desc_start_o), .desc_end_o(desc_end_o),
    .desc_len_o(desc_len_o), .desc_ready_i(desc_ready_i),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
    .drop_o(drop_o), .err_o(err_o)
  );

  typedef struct {
    bit          wr;
    int          idx;
    logic [31:0] data;
    int          count;
    bit          drop;
    bit          err;
    bit          valid;
    int          ds;
    int          de;
    int          dl;
  } exp_t;

  typedef struct {
    int s;
    int e;
    int len;
  } desc_t;

  exp_t  sq[$];
  desc_t mq[$];
  int m_mode;       // 0 idle, 1 in message, 2 dropping
  int m_wr_ptr, m_count, m_msg_start, m_beats;
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endfunction

  task automatic model_reset();
    m_mode = 0; m_wr_ptr = 0; m_count = 0; m_msg_start = 0; m_beats = 0;
    mq.delete();
  endtask

  task automatic model_step(input bit wr, input logic [31:0] d, input bit s, input bit e,
                            input bit rdy, output exp_t x);
    int    pre_q;
    bit    qfull;
    desc_t nd;
    pre_q = mq.size();
    qfull = (pre_q == DD);
    x = '{default: 0};
    if (wr) begin
      if (s) begin
        if (m_mode == 1) begin
          x.err = 1; m_count -= m_beats; m_wr_ptr = m_msg_start;
        end
        if (m_count == DEPTH || (e && qfull)) begin
          x.drop = 1; m_mode = e ? 0 : 2;
        end else begin
          x.wr = 1; x.idx = m_wr_ptr; x.data = d;
          if (e) begin
            nd.s = m_wr_ptr; nd.e = m_wr_ptr; nd.len = 1; mq.push_back(nd); m_mode = 0;
          end else begin
            m_msg_start = m_wr_ptr; m_beats = 1; m_mode = 1;
          end
          m_wr_ptr = (m_wr_ptr + 1) % DEPTH; m_count++;
        end
      end else if (m_mode == 0) begin
        x.err = 1;
      end else if (m_mode == 1) begin
        if (m_count == DEPTH) begin
          x.drop = 1; m_count -= m_beats; m_wr_ptr = m_msg_start; m_mode = 2;
        end else if (e && qfull) begin
          x.drop = 1; m_count -= m_beats; m_wr_ptr = m_msg_start; m_mode = 0;
        end else begin
          x.wr = 1; x.idx = m_wr_ptr; x.data = d; m_beats++; m_count++;
          if (e) begin
            nd.s = m_msg_start; nd.e = m_wr_ptr; nd.len = m_beats; mq.push_back(nd); m_mode = 0;
          end
          m_wr_ptr = (m_wr_ptr + 1) % DEPTH;
        end
      end else if (e) begin
        m_mode = 0;
      end
    end
    if (rdy && pre_q > 0) begin
      m_count -= mq[0].len;
      void'(mq.pop_front());
    end
    x.count = m_count;
    x.valid = (mq.size() > 0);
    if (x.valid) begin
      x.ds = mq[0].s; x.de = mq[0].e; x.dl = mq[0].len;
    end
  endtask

  task automatic step(input bit rst, input bit wr, input logic [31:0] d, input bit s,
                      input bit e, input bit rdy);
    exp_t x;
    rst_n = !rst; wr_en_i = wr; data_i = d;
    start_message_i = s; end_message_i = e; desc_ready_i = rdy;
    if (rst) begin
      model_reset();
      x = '{default: 0};
    end else begin
      model_step(wr, d, s, e, rdy, x);
    end
    sq.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic send_msg(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++)
      step(0, 1, base + 32'(i), i == 0, i == n - 1, 0);
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 32'h0, 0, 0, rdy);
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    if (sq.size() > 0) begin
      x = sq.pop_front();
      chk("cam_wr", 32'(cam_wr_o), 32'(x.wr));
      if (x.wr) begin
        chk("cam_wr_index", 32'(cam_wr_index_o), 32'(x.idx));
        chk("cam_wr_data", cam_wr_data_o, x.data);
      end
      chk("count", 32'(count_o), 32'(x.count));
      chk("full", 32'(full_o), 32'(x.count == DEPTH));
      chk("empty", 32'(empty_o), 32'(x.count == 0));
      chk("drop", 32'(drop_o), 32'(x.drop));
      chk("err", 32'(err_o), 32'(x.err));
      chk("desc_valid", 32'(desc_valid_o), 32'(x.valid));
      if (x.valid) begin
        chk("desc_start", 32'(desc_start_o), 32'(x.ds));
        chk("desc_end", 32'(desc_end_o), 32'(x.de));
        chk("desc_len", 32'(desc_len_o), 32'(x.dl));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    rst_n = 1'b0; wr_en_i = 1'b0; data_i = '0;
    start_message_i = 1'b0; end_message_i = 1'b0; desc_ready_i = 1'b0;
    model_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // Three-beat message, then single-beat, then drain.
    step(0, 1, 32'hA1, 1, 0, 0);
    step(0, 1, 32'hA2, 0, 0, 0);
    step(0, 1, 32'hA3, 0, 1, 0);
    idle(0);
    send_msg(1, 32'hB0);
    idle(1);
    idle(1);
    idle(0);

    // Wrap: fill 6, pop, then 5 beats from index 6.
    step(1, 0, 0, 0, 0, 0);
    send_msg(6, 32'hC0);
    idle(1);
    send_msg(5, 32'hD0);
    idle(0);
    idle(1);

    // Full ring: 8-beat message held, new message dropped until its end.
    step(1, 0, 0, 0, 0, 0);
    send_msg(8, 32'hE0);
    send_msg(4, 32'hF0);
    step(0, 1, 32'h55, 0, 0, 0);
    idle(1);
    idle(0);

    // Descriptor queue full: third message dropped at its end beat.
    step(1, 0, 0, 0, 0, 0);
    send_msg(1, 32'h10);
    send_msg(1, 32'h20);
    send_msg(2, 32'h30);
    step(0, 1, 32'h40, 0, 0, 0);
    idle(1);
    idle(1);

    // Restart inside a message rewinds and begins again.
    step(0, 1, 32'h61, 1, 0, 0);
    step(0, 1, 32'h62, 0, 0, 0);
    step(0, 1, 32'h63, 1, 0, 0);
    step(0, 1, 32'h64, 0, 0, 0);
    step(0, 1, 32'h65, 0, 1, 0);
    idle(1);

    // Reset in the middle of a message.
    send_msg(1, 32'h70);
    step(0, 1, 32'h71, 1, 0, 0);
    step(0, 1, 32'h72, 0, 0, 0);
    step(0, 1, 32'h73, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0)
        step(1, 0, 0, 0, 0, 0);
      else
        step(0, $urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 3) == 0,
             $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3);
    end
    idle(0);
    idle(0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/msg_cam_cntrl.md
Name: msg_cam_cntrl

Overview:
Parametrised successor to the single-pointer CAM write controller. Accepts a beat stream framed by start/end flags and drives the write port of an external CAM of 2**ADDR_WIDTH entries used as a ring. Queues one (start, end, length) descriptor per completed message for the downstream parser, and releases CAM space when the parser consumes a descriptor. Adds wrap-around, occupancy tracking, overflow drop with pointer rewind, and a descriptor queue.

Parameters:
DATA_WIDTH, 32, CAM entry width
ADDR_WIDTH, 5, CAM index width; DEPTH = 2**ADDR_WIDTH
DESC_DEPTH, 4, descriptor queue depth (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
wr_en_i  in  1  beat valid
data_i  in  DATA_WIDTH  beat data
start_message_i  in  1  beat is first of message (qualified by wr_en_i)
end_message_i  in  1  beat is last of message (qualified by wr_en_i)
cam_wr_o  out  1  CAM write strobe
cam_wr_index_o  out  ADDR_WIDTH  CAM write index
cam_wr_data_o  out  DATA_WIDTH  CAM write data
desc_valid_o  out  1  descriptor available
desc_start_o  out  ADDR_WIDTH  first CAM index of message
desc_end_o  out  ADDR_WIDTH  last CAM index of message
desc_len_o  out  ADDR_WIDTH+1  beat count, 1..DEPTH
desc_ready_i  in  1  parser consumes descriptor
full_o  out  1  count == DEPTH
empty_o  out  1  count == 0
count_o  out  ADDR_WIDTH+1  occupied CAM entries (committed + in-progress)
drop_o  out  1  one-cycle pulse: message discarded
err_o  out  1  one-cycle pulse: framing error

Behaviour:
- Reset (rst_n low at clk edge): wr_ptr=0, rd_ptr=0, count=0, state IDLE, descriptor queue empty; all outputs 0 except empty_o=1.
- FSM in package enum: IDLE, IN_MSG, DROP.
- IDLE: beat with start -> accept; start&end in same beat -> single-beat message, commit, stay IDLE; start only -> IN_MSG, latch msg_start=wr_ptr. Beat without start -> ignored, err_o pulse.
- IN_MSG: beat accepted if count<DEPTH; end beat commits and returns to IDLE. Beat with start -> current message abandoned (wr_ptr and count rewound to msg_start), err_o pulse, new message begun at rewound pointer.
- Accepted beat: cam_wr_o/index/data registered, asserted exactly 1 cycle after the beat; wr_ptr += 1 modulo DEPTH (natural wrap); count += 1.
- Overflow: beat in IN_MSG while count==DEPTH -> rewind wr_ptr=msg_start, count -= beats of current message, drop_o pulse, state DROP. Same for start&end single beat when full (no write, drop_o, stay IDLE).
- DROP: all beats discarded; end beat -> IDLE; start beat -> treated as IDLE start.
- Commit: if descriptor queue full at end beat -> message dropped as overflow (rewind, drop_o), no descriptor. Otherwise descriptor pushed; desc_valid_o rises 1 cycle after end beat.
- Descriptor length = end-start+1 modulo DEPTH, with 0 encoded as DEPTH.
- Pop: desc_valid_o & desc_ready_i -> rd_ptr = desc_end+1, count -= desc_len. Same-cycle accept and pop: count updated by net (+1 - len). desc_ready_i with queue empty ignored.
- Descriptors show-ahead: head fields valid whenever desc_valid_o=1.
- full_o/empty_o/count_o derived from registered count, no extra latency.
- Reset mid-message discards everything; no drop_o on reset.

Optional Feature:
MSG_CAM_CNTRL_STATS_EN: defined -> adds outputs msg_cnt_o[15:0] (descriptors committed) and drop_cnt_o[15:0] (drop_o pulses), both saturating at 16'hFFFF, cleared by reset. Undefined -> ports and counters absent, all other behaviour identical.

Decomposition:
- Package cam_cntrl_pkg: state enum cam_cntrl_state_e, packed struct cam_desc_t {start, end, len} parameterised via localparam widths for default ADDR_WIDTH, plus function to compute length with DEPTH encoding.
- Sub-module msg_desc_fifo: synchronous show-ahead FIFO of DESC_DEPTH descriptors with full/empty; msg_cam_cntrl instantiates it once.

Test Plan:
- ADDR_WIDTH=3: beats S,x,E (data 0xA1,0xA2,0xA3) -> cam_wr at idx 0,1,2 one cycle later; descriptor {0,2,3}; count_o=3.
- Single beat with start&end -> descriptor {n,n,1}; pop -> count_o back to previous value, empty_o=1 if sole message.
- Fill 6, pop, then 5-beat message from wr_ptr=6 -> writes 6,7,0,1,2; descriptor {6,2,5}; wrap correct.
- DEPTH=8, one unpopped 8-beat message, new message S -> drop_o, wr_ptr unchanged, count_o=8, continuation beats ignored until E, then IDLE.
- DESC_DEPTH=2 full, third message end -> drop_o, count_o excludes its beats; beat without start in IDLE -> err_o, no write.
- Reset asserted in IN_MSG after 3 beats -> next cycle count_o=0, empty_o=1, desc_valid_o=0, cam_wr_o=0.
